riscv_dmem_resp: RTL
====================

RISCV_DMEM_RESP -- requirements
Module: riscv_dmem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, number of word-address bits (memory depth 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT_CYC, default 1, range 0..15, number of wait-state cycles inserted before each acknowledge.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, reset; synchronous and active-low.
REQ-005 SHALL have port mem_req_i, input, 1, request strobe from the core data-bus initiator; held high until acknowledged.
REQ-006 SHALL have port addr_mem_i, input, [31:2], word address of the access.
REQ-007 SHALL have port dat_mem_i, input, 32, write data.
REQ-008 SHALL have port mem_we_i, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port mem_be_i, input, 4, byte-lane write enables; bit n covers data bits [8n+7:8n].
REQ-010 SHALL have port dbus_ack_o, output, 1, one-cycle acknowledge of a completed access.
REQ-011 SHALL have port dat_rd_o, output, 32, load data; valid while dbus_ack_o is high and held until the next acknowledge.
REQ-012 SHALL have port dbus_err_o, output, 1, address-out-of-range flag; qualified by dbus_ack_o.

Function
REQ-013 SHALL implement an FSM with states IDLE, WAIT, ACK.
REQ-014 IDLE: when mem_req_i = 1 at a rising edge, SHALL latch addr_mem_i, dat_mem_i, mem_we_i and mem_be_i, then go to WAIT (WAIT_CYC > 0) or ACK (WAIT_CYC = 0).
REQ-015 WAIT: on entry SHALL load a 4-bit down-counter with WAIT_CYC-1, decrement it each cycle, and go to ACK on the edge where it reads 0.
REQ-016 The memory access SHALL be performed on the edge that enters ACK, using the latched request.
REQ-017 ACK: SHALL drive dbus_ack_o = 1 for exactly one cycle, then return to IDLE unconditionally.
REQ-018 Latency: with the request sampled at edge k, dbus_ack_o SHALL be high during the cycle following edge k+WAIT_CYC.
REQ-019 While the FSM is in WAIT or ACK, mem_req_i and all request inputs SHALL be ignored.
REQ-020 The initiator is required to drop mem_req_i on the edge at which it samples dbus_ack_o high, so IDLE never re-accepts a completed request.
REQ-021 A store SHALL write only the byte lanes whose mem_be_i bit is 1.
REQ-022 A store with mem_be_i = 4'b0000 SHALL write nothing and still be acknowledged.
REQ-023 A store SHALL leave dat_rd_o unchanged.
REQ-024 A load SHALL register the full 32-bit addressed word into dat_rd_o; mem_be_i is ignored for loads.
REQ-025 Out of range means addr_mem_i[31:ADDR_W+2] is nonzero.
REQ-026 An out-of-range access SHALL write no memory, SHALL set dat_rd_o = 32'h0 for a load, and SHALL assert dbus_err_o together with dbus_ack_o.
REQ-027 dbus_err_o SHALL be 0 whenever dbus_ack_o is 0.
REQ-028 Memory SHALL be a synchronous array with no read-during-write hazard, since one access occurs per transaction.

Reset
REQ-029 With rst_ni = 0 at a rising edge, the block SHALL set FSM = IDLE, counter = 0, dbus_ack_o = 0, dbus_err_o = 0, dat_rd_o = 32'h0, and latched request registers = 0.
REQ-030 Reset asserted during WAIT or ACK SHALL abort the transaction: no acknowledge, and no memory write if the write edge has not yet occurred.
REQ-031 Memory contents SHALL NOT be cleared by reset.
REQ-032 The first request SHALL be accepted on the first edge with rst_ni = 1 and mem_req_i = 1.

Verification
REQ-033 WAIT_CYC=1: store 32'hDEADBEEF, be=4'hF, word 5, request sampled at edge k -> ack high in the cycle after edge k+1, err=0; then load word 5 -> dat_rd_o=32'hDEADBEEF with ack.
REQ-034 Byte lanes: word 7 = 32'h11223344; store 32'hAABBCCDD with be=4'b0101 -> subsequent load returns 32'h11BB33DD.
REQ-035 WAIT_CYC=0 and WAIT_CYC=15: back-to-back loads with mem_req_i dropped on ack -> ack spacing 2 and 17 cycles respectively; each ack exactly one cycle wide.
REQ-036 ADDR_W=10: load at addr_mem_i=30'h400 -> ack=1, err=1, dat_rd_o=0; store at the same address -> err=1 and words 0..1023 unchanged.
REQ-037 Reset mid-operation: WAIT_CYC=3 store to word 2, rst_ni=0 during WAIT -> no ack; word 2 retains its old value; outputs read 0 next cycle; a new load after reset is acknowledged normally.
REQ-038 mem_req_i toggled during WAIT with a different address -> ignored; acknowledged data comes from the originally latched address.

Source files
------------

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder for the core data bus: latches a request, inserts
// WAIT_CYC wait states, performs one byte-masked access and acknowledges it.
module riscv_dmem_resp #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_req_i,
  input  logic [31:2] addr_mem_i,
  input  logic [31:0] dat_mem_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_be_i,
  output logic        dbus_ack_o,
  output logic [31:0] dat_rd_o,
  output logic        dbus_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:2] r_addr;
  logic [31:0] r_wdat;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [2**ADDR_W];

  logic              w_take;
  logic              w_access;
  logic [31:2]       w_addr;
  logic [31:0]       w_wdat;
  logic              w_we;
  logic [3:0]        w_be;
  logic              w_oor;
  logic [ADDR_W-1:0] w_idx;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (mem_req_i) w_next = (WAIT_CYC == 0) ? ACK : WAIT;
      WAIT:    if (r_cnt == 4'd0) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so the
  // request fields bypass the latches in that case.
  assign w_take   = (r_state == IDLE) && mem_req_i;
  assign w_access = (r_state != ACK) && (w_next == ACK);
  assign w_addr   = (r_state == IDLE) ? addr_mem_i : r_addr;
  assign w_wdat   = (r_state == IDLE) ? dat_mem_i  : r_wdat;
  assign w_we     = (r_state == IDLE) ? mem_we_i   : r_we;
  assign w_be     = (r_state == IDLE) ? mem_be_i   : r_be;
  assign w_oor    = |w_addr[31:ADDR_W+2];
  assign w_idx    = w_addr[ADDR_W+1:2];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdat  <= 32'h0;
      r_we    <= 1'b0;
      r_be    <= 4'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_take) begin
        r_cnt  <= CNT_INIT;
        r_addr <= addr_mem_i;
        r_wdat <= dat_mem_i;
        r_we   <= mem_we_i;
        r_be   <= mem_be_i;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access && !w_we) r_rdata <= w_oor ? 32'h0 : r_mem[w_idx];
      r_err <= w_access ? w_oor : 1'b0;
    end
  end

  // Memory has no reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk_i) begin
    if (rst_ni && w_access && w_we && !w_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdat[8*b +: 8];
      end
    end
  end

  assign dbus_ack_o = (r_state == ACK);
  assign dat_rd_o   = r_rdata;
  assign dbus_err_o = r_err & dbus_ack_o;

endmodule
